axis_to_uart_tx: RTL and testbench
==================================

# axis_to_uart_tx

Parametrised successor to the byte-only RS232 transmitter. It serialises an AXI-stream word onto a UART line with a configurable word length, parity mode and stop-bit count. An exact per-bit baud period is held for every bit. Optional CTS hardware flow control is compiled in by macro. It sits between an AXI-stream producer (FIFO, packetiser) and the board TXD pin.

## Interface
- CLOCK_FREQ, 133000000 (real): clock frequency in Hz.
- BAUD_RATE, 115200 (real): line rate in baud.
- DATA_BITS, 8: data bits per frame, legal 5..9.
- PARITY, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame, legal 1 or 2.
- clock  in  1  system clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- idata  in  DATA_BITS  word to send; bit 0 is sent first.
- ivalid  in  1  AXI-stream valid.
- iready  out  1  AXI-stream ready; registered.
- txd_pin  out  1  serial output; connects to the receiver's RXD; registered.
- ctsn_pin  in  1  clear-to-send, active low; connects to the receiver's RTSn.
- busy  out  1  high while a frame is on the line; registered.

## Operation
- BAUD_COUNT = integer(CLOCK_FREQ/BAUD_RATE), must be >= 2. An illegal parameter value is a fatal elaboration error.
- Frame order: 1 start bit (0), then DATA_BITS bits LSB first, then the parity bit if PARITY != 0, then STOP_BITS stop bits (1).
- FRAME = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS; range 7..13.
- Parity is computed over idata at acceptance.
  - Odd: the total count of ones in data+parity is odd.
  - Even: that count is even.
- Two states:
  - IDLE: txd_pin = 1, busy = 0.
  - SEND: a bit index 0..FRAME-1 and a baud down-counter are active.
- Transfer happens on a cycle with iready && ivalid. The block then:
  - latches the word and parity into a shift register,
  - goes to SEND with bit index 0,
  - loads the baud counter.
- In SEND, each bit is held for exactly BAUD_COUNT cycles. When the counter expires on the last bit (index FRAME-1), the block returns to IDLE.
- The baud counter is reloaded on every accept, so there is no phase carry-over between frames.
- iready = IDLE && cts_ok. cts_ok is constant 1 without the macro. ivalid while iready is low is ignored; the block does not drop or reorder words.
- idata is sampled only in the accept cycle and may change afterwards.
- Reset, asserted at any time including mid-frame, forces immediately:
  - txd_pin = 1,
  - iready = 0,
  - busy = 0,
  - state IDLE.
  
  A partial frame is abandoned. The first possible iready = 1 is the first clock edge after reset is released.

## Timing
- Reset values: txd_pin = 1, iready = 0, busy = 0.
- Accept at edge t:
  - Start bit drives txd_pin during cycles t+1 .. t+BAUD_COUNT.
  - Bit k occupies cycles t+1+k*BAUD_COUNT .. t+(k+1)*BAUD_COUNT.
  - busy = 1 and iready = 0 from cycle t+1 through t+FRAME*BAUD_COUNT.
- Cycle t+FRAME*BAUD_COUNT+1: IDLE, txd_pin = 1, iready = 1 if cts_ok.
  - With ivalid held high, frames repeat every FRAME*BAUD_COUNT+1 cycles.
  - The idle gap between frames is 1 cycle.
- Counter widths are sized with $clog2 from BAUD_COUNT and FRAME. No wrap-around is reachable.

## Configuration
- AXIS_TO_UART_CTS_EN defined:
  - ctsn_pin passes through a 2-flop synchroniser; both flops reset to 1.
  - cts_ok = synchronised ctsn == 0.
  - iready falls within 3 cycles of ctsn_pin rising while IDLE. It rises within 3 cycles of ctsn_pin falling.
  - ctsn_pin rising during SEND never aborts or stretches the current frame; the frame completes and iready stays low afterwards.
- AXIS_TO_UART_CTS_EN undefined:
  - ctsn_pin is ignored and no synchroniser is instantiated.
  - iready follows IDLE only.

## Test plan
Common parameters for all scenarios: CLOCK_FREQ = 1e6, BAUD_RATE = 1e5, so BAUD_COUNT = 10.
- 8N1 0x55 -> txd_pin is 0,1,0,1,0,1,0,1,0,1 at 10 cycles each. busy is high for exactly 100 cycles. iready is high on cycle 101 after the accept.
- 7E1 (DATA_BITS = 7, PARITY = 2) 0x07 -> data bits 1,1,1,0,0,0,0, then parity 1, then stop 1. The frame lasts 100 cycles.
- 8O2 0x03 -> parity bit 1 followed by two stop bits. The frame lasts 120 cycles and idata is not accepted again before cycle 121.
- Back-to-back 8N1, ivalid held high with 0x00 then 0xFF -> accepts are exactly 101 cycles apart. txd_pin is 1 for 11 cycles between the two frames (10 stop cycles plus 1 idle gap).
- CTS_EN: ctsn_pin = 1 out of reset -> iready stays 0.
  - Drop ctsn_pin -> iready = 1 within 3 cycles.
  - Raise ctsn_pin 20 cycles into a frame -> the frame completes intact and iready stays 0.
- Pull resetn low 35 cycles into a frame -> txd_pin = 1, busy = 0 and iready = 0 asynchronously. A new word sent after release is transmitted correctly from its start bit.

Source files
------------

// File: rtl/axis_to_uart_tx.sv
// AXI-stream to UART transmitter: configurable word length, parity and stop bits, exact per-bit baud period.
// Define AXIS_TO_UART_CTS_EN to compile in CTS hardware flow control on ctsn_pin.
module axis_to_uart_tx #(
  parameter real CLOCK_FREQ = 133000000.0,
  parameter real BAUD_RATE  = 115200.0,
  parameter int  DATA_BITS  = 8,
  parameter int  PARITY     = 0,
  parameter int  STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [DATA_BITS-1:0] idata,
  input  logic                 ivalid,
  output logic                 iready,
  output logic                 txd_pin,
  input  logic                 ctsn_pin,
  output logic                 busy
);

  localparam int BAUD_COUNT = int'(CLOCK_FREQ / BAUD_RATE);
  localparam int FRAME      = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
  localparam int PAY_W      = FRAME - 1;
  localparam int BAUD_W     = $clog2(BAUD_COUNT);
  localparam int IDX_W      = $clog2(FRAME);

  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(BAUD_COUNT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME - 1);

  if (BAUD_COUNT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_err
    $fatal(1, "axis_to_uart_tx: illegal parameter value");
  end

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [PAY_W-1:0]  shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              iready_q, iready_d;
  logic [PAY_W-1:0]  payload;
  logic              accept;
  logic              cts_ok;

`ifdef AXIS_TO_UART_CTS_EN
  logic cts_meta_q, cts_sync_q;

  // Both stages reset to "not clear", so nothing is accepted until the receiver asserts RTSn.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= ctsn_pin;
      cts_sync_q <= cts_meta_q;
    end
  end

  assign cts_ok = ~cts_sync_q;
`else
  logic unused_ctsn;
  assign unused_ctsn = ctsn_pin;
  assign cts_ok      = 1'b1;
`endif

  // Everything after the start bit: data LSB first, optional parity, then stop bits (the 1s fill).
  always_comb begin
    payload                  = '1;
    payload[DATA_BITS-1:0]   = idata;
    if (PARITY == 1) begin
      payload[DATA_BITS] = ~(^idata);
    end else if (PARITY == 2) begin
      payload[DATA_BITS] = ^idata;
    end
  end

  assign accept = iready_q && ivalid;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    baud_cnt_d = baud_cnt_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    busy_d     = busy_q;

    case (state_q)
      S_IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (accept) begin
          state_d    = S_SEND;
          bit_idx_d  = '0;
          baud_cnt_d = BAUD_LOAD;
          shift_d    = payload;
          txd_d      = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_SEND: begin
        if (baud_cnt_q != '0) begin
          baud_cnt_d = baud_cnt_q - 1'b1;
        end else if (bit_idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          txd_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          bit_idx_d  = bit_idx_q + 1'b1;
          baud_cnt_d = BAUD_LOAD;
          txd_d      = shift_q[0];
          shift_d    = {1'b1, shift_q[PAY_W-1:1]};
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Ready is registered, so it is derived from where the FSM is going, not where it is.
    iready_d = (state_d == S_IDLE) && cts_ok;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      bit_idx_q  <= '0;
      baud_cnt_q <= '0;
      shift_q    <= '1;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      iready_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      baud_cnt_q <= baud_cnt_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      iready_q   <= iready_d;
    end
  end

  assign txd_pin = txd_q;
  assign busy    = busy_q;
  assign iready  = iready_q;

endmodule

// File: tb/tb_axis_to_uart_tx.sv
// Scoreboard bench for axis_to_uart_tx: 8N1, 7E1 and 8O2 instances at BAUD_COUNT = 10.
// Expected line bits are queued when a word is offered and popped one baud period at a time.
module tb_axis_to_uart_tx;

  localparam int BC = 10;

  logic       clock    = 1'b0;
  logic       resetn   = 1'b0;
  logic       ctsn_pin = 1'b1;
  logic       ivalid [3];
  logic [8:0] idata  [3];
  logic       iready [3];
  logic       txd    [3];
  logic       busy   [3];

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  logic exp_q [$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  axis_to_uart_tx #(.CLOCK_FREQ(1.0e6), .BAUD_RATE(1.0e5), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clock(clock), .resetn(resetn), .idata(idata[0][7:0]), .ivalid(ivalid[0]), .iready(iready[0]),
    .txd_pin(txd[0]), .ctsn_pin(ctsn_pin), .busy(busy[0]));

  axis_to_uart_tx #(.CLOCK_FREQ(1.0e6), .BAUD_RATE(1.0e5), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
    .clock(clock), .resetn(resetn), .idata(idata[1][6:0]), .ivalid(ivalid[1]), .iready(iready[1]),
    .txd_pin(txd[1]), .ctsn_pin(ctsn_pin), .busy(busy[1]));

  axis_to_uart_tx #(.CLOCK_FREQ(1.0e6), .BAUD_RATE(1.0e5), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_8o2 (
    .clock(clock), .resetn(resetn), .idata(idata[2][7:0]), .ivalid(ivalid[2]), .iready(iready[2]),
    .txd_pin(txd[2]), .ctsn_pin(ctsn_pin), .busy(busy[2]));

  function automatic int frame_cycles(input int nb, input int par, input int sb);
    return (1 + nb + ((par != 0) ? 1 : 0) + sb) * BC;
  endfunction

  // Called at the falling edge of the first cycle after the accept edge.
  task automatic check_frame(input int u, input logic [8:0] d, input int nb, input int par,
                             input int sb, input logic rdy_end, input string name);
    int   ones = 0;
    int   k    = 0;
    logic b;
    exp_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (par == 1) exp_q.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
    if (par == 2) exp_q.push_back((ones % 2 == 1) ? 1'b1 : 1'b0);
    for (int i = 0; i < sb; i++) exp_q.push_back(1'b1);
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      for (int c = 0; c < BC; c++) begin
        vectors++;
        if ({txd[u], busy[u], iready[u]} !== {b, 2'b10}) begin
          miscompares++;
          $display("FAIL %s bit%0d cycle%0d: txd/busy/iready got %b%b%b expected %b10",
                   name, k, c, txd[u], busy[u], iready[u], b);
        end
        @(negedge clock);
      end
      k++;
    end
    vectors++;
    if ({txd[u], busy[u], iready[u]} !== {2'b10, rdy_end}) begin
      miscompares++;
      $display("FAIL %s end: txd/busy/iready got %b%b%b expected 10%b",
               name, txd[u], busy[u], iready[u], rdy_end);
    end
  endtask

  task automatic wait_ready(input int u, input string name);
    for (int i = 0; i < 40 && iready[u] !== 1'b1; i++) @(negedge clock);
    vectors++;
    if (iready[u] !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready timeout: iready got %b expected 1", name, iready[u]);
    end
  endtask

  task automatic send_one(input int u, input logic [8:0] d, input int nb, input int par,
                          input int sb, input string name);
    ivalid[u] = 1'b1;
    idata[u]  = d;
    wait_ready(u, name);
    @(posedge clock);
    @(negedge clock);
    ivalid[u] = 1'b0;
    idata[u]  = 9'($urandom);
    check_frame(u, d, nb, par, sb, 1'b1, name);
  endtask

  task automatic back_to_back(input int u, input logic [8:0] d0, input logic [8:0] d1, input int nb,
                              input int par, input int sb, input string name);
    int c0;
    ivalid[u] = 1'b1;
    idata[u]  = d0;
    wait_ready(u, name);
    c0 = cyc;
    @(posedge clock);
    @(negedge clock);
    idata[u] = d1;
    check_frame(u, d0, nb, par, sb, 1'b1, {name, "_w0"});
    vectors++;
    if (cyc - c0 !== frame_cycles(nb, par, sb) + 1) begin
      miscompares++;
      $display("FAIL %s accept spacing: got %0d expected %0d", name, cyc - c0,
               frame_cycles(nb, par, sb) + 1);
    end
    @(posedge clock);
    @(negedge clock);
    ivalid[u] = 1'b0;
    check_frame(u, d1, nb, par, sb, 1'b1, {name, "_w1"});
  endtask

  task automatic test_reset();
    logic exp_rdy;
`ifdef AXIS_TO_UART_CTS_EN
    exp_rdy = 1'b0;
`else
    exp_rdy = 1'b1;
`endif
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    for (int u = 0; u < 3; u++) begin
      vectors++;
      if ({txd[u], busy[u], iready[u]} !== 3'b100) begin
        miscompares++;
        $display("FAIL reset u%0d: txd/busy/iready got %b%b%b expected 100", u, txd[u], busy[u], iready[u]);
      end
    end
    resetn = 1'b1;
    @(negedge clock);
    for (int u = 0; u < 3; u++) begin
      vectors++;
      if (iready[u] !== exp_rdy) begin
        miscompares++;
        $display("FAIL reset_release u%0d: iready got %b expected %b", u, iready[u], exp_rdy);
      end
    end
  endtask

  task automatic test_cts();
`ifdef AXIS_TO_UART_CTS_EN
    repeat (10) @(negedge clock);
    vectors++;
    if (iready[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL cts_blocked: iready got %b expected 0", iready[0]);
    end
    ctsn_pin = 1'b0;
    for (int i = 0; i < 3 && iready[0] !== 1'b1; i++) @(negedge clock);
    vectors++;
    if (iready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL cts_release: iready got %b expected 1 within 3 cycles", iready[0]);
    end
    ivalid[0] = 1'b1;
    idata[0]  = 9'h03C;
    wait_ready(0, "cts_hold");
    @(posedge clock);
    @(negedge clock);
    ivalid[0] = 1'b0;
    fork
      check_frame(0, 9'h03C, 8, 0, 1, 1'b0, "cts_hold");
      begin
        repeat (20) @(negedge clock);
        ctsn_pin = 1'b1;
      end
    join
    repeat (5) @(negedge clock);
    vectors++;
    if (iready[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL cts_after_frame: iready got %b expected 0", iready[0]);
    end
    ctsn_pin = 1'b0;
    wait_ready(0, "cts_reopen");
`else
    ctsn_pin = 1'b1;
    send_one(0, 9'h096, 8, 0, 1, "cts_ignored");
    ctsn_pin = 1'b0;
    @(negedge clock);
    vectors++;
    if (iready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL cts_ignored_idle: iready got %b expected 1", iready[0]);
    end
`endif
  endtask

  task automatic test_8n1();
    send_one(0, 9'h055, 8, 0, 1, "8n1_55");
    send_one(0, 9'h0F0, 8, 0, 1, "8n1_f0");
  endtask

  task automatic test_7e1();
    send_one(1, 9'h007, 7, 2, 1, "7e1_07");
    send_one(1, 9'h05A, 7, 2, 1, "7e1_5a");
  endtask

  task automatic test_8o2();
    back_to_back(2, 9'h003, 9'h0A5, 8, 1, 2, "8o2");
  endtask

  task automatic test_back_to_back();
    back_to_back(0, 9'h000, 9'h0FF, 8, 0, 1, "b2b_8n1");
  endtask

  task automatic test_reset_mid();
    ivalid[0] = 1'b1;
    idata[0]  = 9'h0C3;
    wait_ready(0, "rst_mid");
    @(posedge clock);
    @(negedge clock);
    ivalid[0] = 1'b0;
    repeat (34) @(negedge clock);
    #1 resetn = 1'b0;
    #1;
    vectors++;
    if ({txd[0], busy[0], iready[0]} !== 3'b100) begin
      miscompares++;
      $display("FAIL rst_mid async: txd/busy/iready got %b%b%b expected 100", txd[0], busy[0], iready[0]);
    end
    exp_q.delete();
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    send_one(0, 9'h0A3, 8, 0, 1, "rst_mid_resend");
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      ivalid[u] = 1'b0;
      idata[u]  = '0;
    end
    test_reset();
    test_cts();
    test_8n1();
    test_7e1();
    test_8o2();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
